// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 encryptor: one key word per cycle, one round per cycle.
// The expanded key schedule is kept for reuse by later blocks.
package aes_pkg;
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

module sbox
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  assign y_o = SBOX[a_i];
endmodule

module sbox_32bit (
  input  logic [31:0] a_i,
  output logic [31:0] y_o
);
  for (genvar k = 0; k < 4; k++) begin : g_b
    sbox u_sb (.a_i(a_i[8*k +: 8]), .y_o(y_o[8*k +: 8]));
  end
endmodule

module shift_rows (
  input  logic [127:0] a_i,
  output logic [127:0] y_o
);
  for (genvar r = 0; r < 4; r++) begin : g_r
    for (genvar c = 0; c < 4; c++) begin : g_c
      assign y_o[127-8*(r+4*c) -: 8] =
        a_i[127-8*(r+4*((c+r)%4)) -: 8];
    end
  end
endmodule

module mix_col
  import aes_pkg::*;
(
  input  logic [31:0] a_i,
  output logic [31:0] y_o
);
  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = a_i;
  assign y_o[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
  assign y_o[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
  assign y_o[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
  assign y_o[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
endmodule

module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter bit EN_192 = 1'b1,
  parameter bit EN_256 = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [255:0] in_key,
  input  logic [1:0]   in_key_len,
  input  logic         in_new_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_err
);
  typedef enum logic [1:0] {IDLE, KEXP, ROUND, OUTPUT} fsm_e;

  fsm_e         st_q;
  logic         key_valid_q;
  logic [1:0]   klen_q;
  logic [127:0] state_q;
  logic [5:0]   i_q;
  logic [2:0]   j_q;
  logic [7:0]   rcon_q;
  logic [3:0]   rnd_q;
  logic         out_valid_q;
  logic         out_err_q;
  logic [127:0] out_data_q;
  logic [31:0]  w_q [60];

  function automatic logic [3:0] nk_of(input logic [1:0] l);
    unique case (l)
      2'b01:   return 4'd6;
      2'b10:   return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] l);
    unique case (l)
      2'b01:   return 4'd12;
      2'b10:   return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  logic accept, new_key, len_ok;
  logic [3:0] nk, nr;
  logic [5:0] last_w;

  assign in_ready = (st_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign new_key  = in_new_key || !key_valid_q;
  assign len_ok   = (in_key_len == 2'b00)
                 || (in_key_len == 2'b01 && EN_192)
                 || (in_key_len == 2'b10 && EN_256);
  assign nk       = nk_of(klen_q);
  assign nr       = nr_of(klen_q);
  assign last_w   = {nr, 2'b11};

  // Key expansion datapath: one new word w[i] per cycle
  logic [31:0] prev_w, back_w, sub_in, sub_out, temp, wnew_d;
  assign prev_w = w_q[i_q - 6'd1];
  assign back_w = w_q[i_q - {2'b00, nk}];
  assign sub_in = (j_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]}
                                : prev_w;
  sbox_32bit u_ksub (.a_i(sub_in), .y_o(sub_out));

  always_comb begin
    temp = prev_w;
    if (j_q == 3'd0)
      temp = sub_out ^ {rcon_q, 24'h0};
    else if (nk == 4'd8 && j_q == 3'd4)
      temp = sub_out;
  end
  assign wnew_d = back_w ^ temp;

  // Round datapath
  logic [127:0] sb, sr, mc, rk, round_d, w0;
  for (genvar c = 0; c < 4; c++) begin : g_col
    sbox_32bit u_sb (
      .a_i(state_q[127-32*c -: 32]),
      .y_o(sb[127-32*c -: 32])
    );
    mix_col u_mc (
      .a_i(sr[127-32*c -: 32]),
      .y_o(mc[127-32*c -: 32])
    );
  end
  shift_rows u_sr (.a_i(sb), .y_o(sr));

  assign rk = {w_q[{rnd_q, 2'd0}], w_q[{rnd_q, 2'd1}],
               w_q[{rnd_q, 2'd2}], w_q[{rnd_q, 2'd3}]};
  assign round_d = ((rnd_q == nr) ? sr : mc) ^ rk;
  assign w0 = {w_q[0], w_q[1], w_q[2], w_q[3]};

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (accept && new_key && len_ok) begin
        for (int k = 0; k < 8; k++)
          w_q[k] <= in_key[255-32*k -: 32];
      end else if (st_q == KEXP) begin
        w_q[i_q] <= wnew_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      key_valid_q <= 1'b0;
      klen_q      <= 2'b00;
      state_q     <= '0;
      i_q         <= '0;
      j_q         <= '0;
      rcon_q      <= 8'h01;
      rnd_q       <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (accept && new_key && len_ok) begin
            klen_q      <= in_key_len;
            key_valid_q <= 1'b1;
            state_q     <= in_data ^ in_key[255:128];
            i_q         <= {2'b00, nk_of(in_key_len)};
            j_q         <= 3'd0;
            rcon_q      <= 8'h01;
            st_q        <= KEXP;
          end else if (accept && new_key) begin
            key_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            st_q        <= OUTPUT;
          end else if (accept) begin
            state_q <= in_data ^ w0;
            rnd_q   <= 4'd1;
            st_q    <= ROUND;
          end
        end
        KEXP: begin
          i_q <= i_q + 6'd1;
          j_q <= ({1'b0, j_q} == nk - 4'd1) ? 3'd0 : j_q + 3'd1;
          if (j_q == 3'd0)
            rcon_q <= xtime(rcon_q);
          if (i_q == last_w) begin
            rnd_q <= 4'd1;
            st_q  <= ROUND;
          end
        end
        ROUND: begin
          state_q <= round_d;
          rnd_q   <= rnd_q + 4'd1;
          if (rnd_q == nr) begin
            out_data_q  <= round_d;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b1;
            st_q        <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            st_q        <= IDLE;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;
  assign out_data  = out_data_q;
endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed FIPS-197 vectors, latency, back-pressure, error and reset checks
// for aes_encrypt_iter.
module tb_aes_encrypt_iter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [255:0] in_key;
  logic [1:0]   in_key_len;
  logic         in_new_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_err;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128 =
    {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 =
    {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_encrypt_iter #(.EN_192(1'b1), .EN_256(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_key     (in_key),
    .in_key_len (in_key_len),
    .in_new_key (in_new_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [127:0] d, input logic [255:0] k,
                       input logic [1:0] l, input logic nkey);
    int t;
    in_data = d; in_key = k; in_key_len = l; in_new_key = nkey;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int start, output int lat);
    lat = start;
    while (out_valid !== 1'b1 && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if (out_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_err: got %b want 0", out_err);
    end
    n_cmp++;
    if (out_data !== 128'h0) begin
      n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_aes128;
    int lat;
    issue(PT, K128, 2'b00, 1'b1);
    // junk request during expansion must be ignored
    in_valid = 1'b1; in_data = '1; in_key = '1;
    in_key_len = 2'b01; in_new_key = 1'b1;
    lat = 0;
    repeat (10) begin @(posedge clk); #1; lat++; end
    in_valid = 1'b0;
    wait_out(lat, lat);
    n_cmp++;
    if (lat !== 50) begin
      n_bad++; $display("FAIL aes128_latency: got %0d want 50", lat);
    end
    n_cmp++;
    if (out_data !== CT128) begin
      n_bad++; $display("FAIL aes128_data: got %h want %h", out_data, CT128);
    end
    n_cmp++;
    if (out_err !== 1'b0) begin
      n_bad++; $display("FAIL aes128_err: got %b want 0", out_err);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL aes128_release: got valid=%b ready=%b want 0/1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_aes192_reuse;
    int lat;
    issue(PT, K192, 2'b01, 1'b1);
    wait_out(0, lat);
    n_cmp++;
    if (lat !== 58) begin
      n_bad++; $display("FAIL aes192_latency: got %0d want 58", lat);
    end
    n_cmp++;
    if (out_data !== CT192) begin
      n_bad++; $display("FAIL aes192_data: got %h want %h", out_data, CT192);
    end
    @(posedge clk); #1;
    // reuse: in_key and in_key_len are garbage and must be ignored
    issue(PT, '1, 2'b11, 1'b0);
    wait_out(0, lat);
    n_cmp++;
    if (lat !== 12) begin
      n_bad++; $display("FAIL reuse192_latency: got %0d want 12", lat);
    end
    n_cmp++;
    if (out_data !== CT192) begin
      n_bad++; $display("FAIL reuse192_data: got %h want %h", out_data, CT192);
    end
    n_cmp++;
    if (out_err !== 1'b0) begin
      n_bad++; $display("FAIL reuse192_err: got %b want 0", out_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_aes256;
    int lat;
    issue(PT, K256, 2'b10, 1'b1);
    wait_out(0, lat);
    n_cmp++;
    if (lat !== 66) begin
      n_bad++; $display("FAIL aes256_latency: got %0d want 66", lat);
    end
    n_cmp++;
    if (out_data !== CT256) begin
      n_bad++; $display("FAIL aes256_data: got %h want %h", out_data, CT256);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int lat;
    out_ready = 1'b0;
    issue(PT, K128, 2'b00, 1'b0);
    wait_out(0, lat);
    n_cmp++;
    if (lat !== 14) begin
      n_bad++; $display("FAIL bp_latency: got %0d want 14", lat);
    end
    in_valid = 1'b1; in_data = '0; in_new_key = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== CT256 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h r=%b want 1/%h/0",
                 c, out_valid, out_data, in_ready, CT256);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release: got valid=%b ready=%b want 0/1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_bad_len;
    int lat;
    issue(PT, K128, 2'b11, 1'b1);
    wait_out(0, lat);
    n_cmp++;
    if (lat !== 0) begin
      n_bad++; $display("FAIL badlen_latency: got %0d want 0", lat);
    end
    n_cmp++;
    if (out_err !== 1'b1 || out_data !== 128'h0) begin
      n_bad++;
      $display("FAIL badlen_out: got err=%b d=%h want 1/0", out_err, out_data);
    end
    @(posedge clk); #1;
    issue(PT, K128, 2'b00, 1'b0);
    wait_out(0, lat);
    n_cmp++;
    if (lat !== 50) begin
      n_bad++; $display("FAIL badlen_forced_latency: got %0d want 50", lat);
    end
    n_cmp++;
    if (out_data !== CT128 || out_err !== 1'b0) begin
      n_bad++;
      $display("FAIL badlen_forced_data: got %h err=%b want %h/0",
               out_data, out_err, CT128);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_round;
    int lat;
    int seen;
    issue(PT, K128, 2'b00, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen !== 0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_abort: got valid_cycles=%0d ready=%b want 0/1",
               seen, in_ready);
    end
    issue(PT, K128, 2'b00, 1'b0);
    wait_out(0, lat);
    n_cmp++;
    if (lat !== 50) begin
      n_bad++; $display("FAIL rst_forced_latency: got %0d want 50", lat);
    end
    n_cmp++;
    if (out_data !== CT128) begin
      n_bad++; $display("FAIL rst_forced_data: got %h want %h", out_data, CT128);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_key = '0;
    in_key_len = 2'b00;
    in_new_key = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_aes128();
    test_aes192_reuse();
    test_aes256();
    test_backpressure();
    test_bad_len();
    test_reset_in_round();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
